jpeg_bit_aligner: RTL and testbench

//  Parametrised successor to the entropy-stream bit window. Accepts ECS bytes, strips FF00 stuffing, detects

---
 rtl/jpeg_bit_aligner_pkg.sv | 17 +
 rtl/jpeg_bit_aligner_if.sv | 29 ++
 rtl/jpeg_bit_aligner_destuff.sv | 42 ++++
 rtl/jpeg_bit_aligner.sv | 135 +++++++++++++
 tb/tb_jpeg_bit_aligner.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/jpeg_bit_aligner_pkg.sv
// Shared constants, FSM encoding and marker helpers for the JPEG entropy-stream bit aligner.
package jpeg_bit_aligner_pkg;
   localparam logic [7:0] MK_FF    = 8'hFF;
   localparam logic [7:0] MK_STUFF = 8'h00;
   localparam logic [7:0] MK_EOI   = 8'hD9;
   localparam logic [7:0] MK_RST0  = 8'hD0;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_MARK = 2'd1,
      ST_PAD  = 2'd2
   } state_e;

   function automatic logic is_rst_marker(input logic [7:0] code);
      return code[7:3] == MK_RST0[7:3];
   endfunction
endpackage

// File: rtl/jpeg_bit_aligner_if.sv
// Byte-in / bit-window-out bundle between header parser, aligner and Huffman decoder.
interface jpeg_bit_aligner_if #(
   parameter int WIN_W = 64,
   parameter int CNT_W = 7
);
   logic [7:0]       din;
   logic             din_valid;
   logic             din_ready;
   logic [WIN_W-1:0] win_out;
   logic [CNT_W-1:0] win_bits;
   logic             win_valid;
   logic             consume_en;
   logic [CNT_W-1:0] consume_n;
   logic             pad_active;
   logic             marker_valid;
   logic [7:0]       marker_code;
   logic             marker_ack;
   logic             err;

   modport master (
      output din, din_valid, consume_en, consume_n, marker_ack,
      input  din_ready, win_out, win_bits, win_valid, pad_active, marker_valid, marker_code, err
   );

   modport slave (
      input  din, din_valid, consume_en, consume_n, marker_ack,
      output din_ready, win_out, win_bits, win_valid, pad_active, marker_valid, marker_code, err
   );
endinterface

// File: rtl/jpeg_bit_aligner_destuff.sv
// Byte classifier: removes FF00 stuffing, swallows FF fill bytes and flags FFxx markers.
module jpeg_bit_aligner_destuff
   import jpeg_bit_aligner_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       byte_en,
   input  logic [7:0] byte_in,
   output logic       append,
   output logic [7:0] append_byte,
   output logic       marker_hit,
   output logic [7:0] marker_code
);
   logic pend_q, pend_d;

   always_comb begin
      pend_d      = pend_q;
      append      = 1'b0;
      append_byte = byte_in;
      marker_hit  = 1'b0;
      marker_code = byte_in;
      if (byte_en) begin
         if (!pend_q) begin
            if (byte_in == MK_FF) pend_d = 1'b1;
            else                  append = 1'b1;
         end else if (byte_in == MK_STUFF) begin
            append      = 1'b1;
            append_byte = MK_FF;
            pend_d      = 1'b0;
         end else if (byte_in != MK_FF) begin
            // FF FF is a fill byte: stay pending until something else shows up
            marker_hit = 1'b1;
            pend_d     = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) pend_q <= 1'b0;
      else        pend_q <= pend_d;
   end
endmodule

// File: rtl/jpeg_bit_aligner.sv
// MSB-aligned bit window over the destuffed ECS byte stream, with RSTn/EOI marker handling.
// Define JPEG_STREAM_RESTART_EN to flush on RST0..7 and check their cyclic order.
module jpeg_bit_aligner
   import jpeg_bit_aligner_pkg::*;
#(
   parameter int WIN_W = 64,
   parameter int BUF_W = 96,
   parameter int CNT_W = 7
) (
   input logic               clk,
   input logic               rst_n,
   jpeg_bit_aligner_if.slave bus
);
   localparam logic [CNT_W-1:0] FILL_LIM  = CNT_W'(BUF_W - 8);
   localparam logic [CNT_W-1:0] WIN_LIM   = CNT_W'(WIN_W);
   localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(8);

   state_e           state_q, state_d;
   logic [BUF_W-1:0] buf_q, buf_d, ins;
   logic [CNT_W-1:0] cnt_q, cnt_d, take, base;
   logic             din_ready_q, din_ready_d;
   logic             mv_q, mv_d, pad_q, pad_d, err_q, err_d;
   logic [7:0]       code_q, code_d;
   logic             accept, append, marker_hit, rst_mk;
   logic [7:0]       append_byte, hit_code;

   assign accept = bus.din_valid & din_ready_q;

   jpeg_bit_aligner_destuff u_destuff (
      .clk         (clk),
      .rst_n       (rst_n),
      .byte_en     (accept),
      .byte_in     (bus.din),
      .append      (append),
      .append_byte (append_byte),
      .marker_hit  (marker_hit),
      .marker_code (hit_code)
   );

`ifdef JPEG_STREAM_RESTART_EN
   logic [2:0] idx_q, idx_d;
   always_ff @(posedge clk) begin
      if (!rst_n) idx_q <= '0;
      else        idx_q <= idx_d;
   end
`endif

   always_comb begin
      // Consume is applied before the append so a byte lands right after the surviving bits
      take  = bus.consume_en ? bus.consume_n : '0;
      base  = (take > cnt_q) ? '0 : cnt_q - take;
      cnt_d = base + (append ? BYTE_BITS : '0);
      ins   = append ? {append_byte, {(BUF_W-8){1'b0}}} : '0;
      buf_d = (buf_q << take) | (ins >> base);

      err_d   = err_q | ((take > cnt_q) && (state_q != ST_PAD));
      state_d = state_q;
      mv_d    = mv_q;
      pad_d   = pad_q;
      code_d  = code_q;
`ifdef JPEG_STREAM_RESTART_EN
      idx_d  = idx_q;
      rst_mk = is_rst_marker(code_q);
`else
      rst_mk = 1'b0;
`endif

      case (state_q)
         ST_FILL: if (marker_hit) begin
            state_d = ST_MARK;
            mv_d    = 1'b1;
            code_d  = hit_code;
`ifdef JPEG_STREAM_RESTART_EN
            if (is_rst_marker(hit_code)) begin
               if (hit_code[2:0] != idx_q) err_d = 1'b1;
               idx_d = idx_q + 3'd1;
            end else if (hit_code != MK_EOI) begin
               err_d = 1'b1;
            end
`else
            if (hit_code != MK_EOI) err_d = 1'b1;
`endif
         end
         ST_MARK: if (bus.marker_ack) begin
            mv_d = 1'b0;
            if (code_q == MK_EOI) begin
               state_d = ST_PAD;
               pad_d   = 1'b1;
            end else begin
               state_d = ST_FILL;
               if (rst_mk) begin
                  cnt_d = '0;
                  buf_d = '0;
               end
            end
         end
         default: ;
      endcase

      // Past EOI every bit below the valid region reads as 1
      if (state_d == ST_PAD) buf_d = buf_d | ({BUF_W{1'b1}} >> cnt_d);
      din_ready_d = (state_d == ST_FILL) && (cnt_d <= FILL_LIM);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_FILL;
         buf_q       <= '0;
         cnt_q       <= '0;
         din_ready_q <= 1'b0;
         mv_q        <= 1'b0;
         pad_q       <= 1'b0;
         err_q       <= 1'b0;
         code_q      <= '0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         din_ready_q <= din_ready_d;
         mv_q        <= mv_d;
         pad_q       <= pad_d;
         err_q       <= err_d;
         code_q      <= code_d;
      end
   end

   assign bus.din_ready    = din_ready_q;
   assign bus.win_out      = buf_q[BUF_W-1 -: WIN_W];
   assign bus.win_bits     = cnt_q;
   assign bus.win_valid    = pad_q | (cnt_q >= WIN_LIM);
   assign bus.pad_active   = pad_q;
   assign bus.marker_valid = mv_q;
   assign bus.marker_code  = code_q;
   assign bus.err          = err_q;
endmodule

// File: tb/tb_jpeg_bit_aligner.sv
// Directed + random bench for jpeg_bit_aligner against a bit-queue reference model.
module tb_jpeg_bit_aligner;
   localparam int WIN_W = 64;
   localparam int BUF_W = 96;
   localparam int CNT_W = 7;
   localparam int MD_FILL = 0, MD_MARK = 1, MD_PAD = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   jpeg_bit_aligner_if #(.WIN_W(WIN_W), .CNT_W(CNT_W)) bus ();

   jpeg_bit_aligner #(.WIN_W(WIN_W), .BUF_W(BUF_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference model: valid bits as a queue, next bit at index 0
   bit         mq[$];
   bit         m_pend, m_err, m_ready;
   int         m_mode, m_idx;
   logic [7:0] m_code;
   int         passes = 0;
   int         total  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic bit restart_code(input logic [7:0] b);
`ifdef JPEG_STREAM_RESTART_EN
      return (b >= 8'hD0) && (b <= 8'hD7);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [WIN_W-1:0] m_win();
      logic [WIN_W-1:0] w;
      for (int i = 0; i < WIN_W; i++)
         w[WIN_W-1-i] = (i < mq.size()) ? mq[i] : (m_mode == MD_PAD);
      return w;
   endfunction

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
   endtask

   task automatic check_all();
      chk("win_out",      64'(bus.win_out), 64'(m_win()));
      chk("win_bits",     64'(bus.win_bits), 64'(mq.size()));
      chk("win_valid",    64'(bus.win_valid), 64'((mq.size() >= WIN_W) || (m_mode == MD_PAD)));
      chk("din_ready",    64'(bus.din_ready), 64'(m_ready));
      chk("marker_valid", 64'(bus.marker_valid), 64'(m_mode == MD_MARK));
      chk("marker_code",  64'(bus.marker_code), 64'(m_code));
      chk("pad_active",   64'(bus.pad_active), 64'(m_mode == MD_PAD));
      chk("err",          64'(bus.err), 64'(m_err));
   endtask

   task automatic step(input bit v, input logic [7:0] b, input bit ce, input int cn, input bit ack);
      bit acc;
      int old_mode;
      bus.din_valid  = v;
      bus.din        = b;
      bus.consume_en = ce;
      bus.consume_n  = CNT_W'(cn);
      bus.marker_ack = ack;
      acc      = v && m_ready;
      old_mode = m_mode;
      if (ce) begin
         if ((cn > mq.size()) && (m_mode != MD_PAD)) m_err = 1'b1;
         for (int i = 0; i < cn; i++) if (mq.size() > 0) void'(mq.pop_front());
      end
      if ((old_mode == MD_MARK) && ack) begin
         if (m_code == 8'hD9) m_mode = MD_PAD;
         else begin
            m_mode = MD_FILL;
            if (restart_code(m_code)) mq.delete();
         end
      end
      if (acc) begin
         if (!m_pend) begin
            if (b == 8'hFF) m_pend = 1'b1;
            else            push_byte(b);
         end else if (b == 8'h00) begin
            push_byte(8'hFF);
            m_pend = 1'b0;
         end else if (b != 8'hFF) begin
            m_pend = 1'b0;
            m_mode = MD_MARK;
            m_code = b;
            if (restart_code(b)) begin
               if (b[2:0] != m_idx[2:0]) m_err = 1'b1;
               m_idx = (m_idx + 1) % 8;
            end else if (b != 8'hD9) m_err = 1'b1;
         end
      end
      m_ready = (m_mode == MD_FILL) && (mq.size() <= BUF_W - 8);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.din_valid = 1'b0; bus.din = '0; bus.consume_en = 1'b0;
      bus.consume_n = '0;   bus.marker_ack = 1'b0;
      @(posedge clk);
      #1;
      mq.delete();
      m_pend = 1'b0; m_err = 1'b0; m_mode = MD_FILL; m_code = '0; m_idx = 0; m_ready = 1'b0;
      check_all();
      rst_n = 1'b1;
      step(0, 8'h00, 0, 0, 0);
   endtask

   initial begin
      logic [7:0] t1 [9] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h09};
      logic [63:0] w;
      logic [7:0] b;
      int cn;
      bit ce, ack;

      // 1: plain bytes fill the window MSB first
      do_reset();
      for (int i = 0; i < 7; i++) step(1, t1[i], 0, 0, 0);
      chk("t1_valid7", 64'(bus.win_valid), 64'd0);
      step(1, t1[7], 0, 0, 0);
      chk("t1_valid8", 64'(bus.win_valid), 64'd1);
      step(1, t1[8], 0, 0, 0);
      chk("t1_win", bus.win_out, 64'h123456789ABCDEF0);
      chk("t1_bits", 64'(bus.win_bits), 64'd72);

      // 2: stuffed FF00 yields one FF byte
      do_reset();
      step(1, 8'hFF, 0, 0, 0);
      step(1, 8'h00, 0, 0, 0);
      step(1, 8'hA5, 0, 0, 0);
      step(0, 8'h00, 1, 4, 0);
      w = bus.win_out;
      chk("t2_msb", 64'(w[63:52]), 64'hFA5);
      chk("t2_bits", 64'(bus.win_bits), 64'd12);

      // 3: fill byte, EOI, then all-ones padding
      do_reset();
      step(1, 8'hFF, 0, 0, 0);
      step(1, 8'hFF, 0, 0, 0);
      step(1, 8'hD9, 0, 0, 0);
      chk("t3_mv", 64'(bus.marker_valid), 64'd1);
      chk("t3_code", 64'(bus.marker_code), 64'hD9);
      step(1, 8'h44, 0, 0, 1);
      chk("t3_pad", 64'(bus.pad_active), 64'd1);
      step(0, 8'h00, 1, 64, 0);
      chk("t3_ones", bus.win_out, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t3_err", 64'(bus.err), 64'd0);

      // 4: restart markers
      do_reset();
      step(1, 8'h11, 0, 0, 0);
      step(1, 8'h22, 0, 0, 0);
      step(1, 8'hFF, 0, 0, 0);
      step(1, 8'hD0, 0, 0, 0);
      step(0, 8'h00, 0, 0, 1);
`ifdef JPEG_STREAM_RESTART_EN
      chk("t4_flush", 64'(bus.win_bits), 64'd0);
      chk("t4_err0", 64'(bus.err), 64'd0);
`else
      chk("t4_keep", 64'(bus.win_bits), 64'd16);
      chk("t4_err0", 64'(bus.err), 64'd1);
`endif
      step(1, 8'h33, 0, 0, 0);
      step(1, 8'hFF, 0, 0, 0);
      step(1, 8'hD2, 0, 0, 0);
      chk("t4_err1", 64'(bus.err), 64'd1);
      step(0, 8'h00, 0, 0, 1);

      // 5: over-consume sets err and clamps; reset clears
      do_reset();
      step(1, 8'h12, 0, 0, 0);
      step(1, 8'h34, 0, 0, 0);
      step(0, 8'h00, 1, 20, 0);
      chk("t5_err", 64'(bus.err), 64'd1);
      chk("t5_bits", 64'(bus.win_bits), 64'd0);
      do_reset();
      chk("t5_clr", 64'(bus.err), 64'd0);

      // 6: streaming at one byte per clock
      for (int i = 0; i < 11; i++) step(1, 8'($urandom_range(0, 254)), 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         chk("t6_ready", 64'(bus.din_ready), 64'd1);
         step(1, 8'($urandom_range(0, 254)), 1, 8, 0);
      end
      chk("t6_bits", 64'(bus.win_bits), 64'd88);

      // Random traffic, reset between rounds so EOI does not end coverage early
      for (int r = 0; r < 4; r++) begin
         do_reset();
         for (int i = 0; i < 150; i++) begin
            cn = $urandom_range(0, 99);
            if (m_pend)
               b = (cn < 60) ? 8'h00 : (cn < 72) ? 8'hFF : (cn < 85) ? 8'(8'hD0 + $urandom_range(0, 7)) :
                   (cn < 88) ? 8'hD9 : 8'($urandom_range(1, 254));
            else
               b = (cn < 12) ? 8'hFF : 8'($urandom_range(0, 255));
            ce = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 49) == 0) cn = $urandom_range(1, WIN_W);
            else if (mq.size() == 0) begin cn = 1; ce = 1'b0; end
            else cn = $urandom_range(1, (mq.size() < WIN_W) ? mq.size() : WIN_W);
            ack = (m_mode == MD_MARK) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 3) != 0, b, ce, cn, ack);
         end
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
